// File: rtl/ahblite_busmatrix_inputstage_dmac.sv
// DMAC-side AHB-Lite bus matrix input stage: pass-through or one-deep address-phase hold with replay.
// Optional: BUSMATRIX_DMAC_SEQ2NONSEQ_EN replays a held SEQ transfer as NONSEQ.
module ahblite_busmatrix_inputstage_dmac (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        HSEL_SUB,
  output logic [31:0] HADDR_SUB,
  output logic [1:0]  HTRANS_SUB,
  output logic        HWRITE_SUB,
  output logic [2:0]  HSIZE_SUB,
  output logic [2:0]  HBURST_SUB,
  output logic [3:0]  HPROT_SUB,
  output logic [31:0] HWDATA_SUB,
  output logic        TRANS_HOLD_SUB,
  input  logic        ACTIVE_SUB,
  input  logic        HREADY_SUB,
  input  logic [31:0] HRDATA_SUB
);

  logic        pend;
  logic        dphase;
  logic [31:0] hold_addr;
  logic [1:0]  hold_trans;
  logic        hold_write;
  logic [2:0]  hold_size;
  logic [2:0]  hold_burst;
  logic [3:0]  hold_prot;
  logic [1:0]  replay_trans;
  logic        trans_req;
  logic        accept;

  assign trans_req = HSEL & HTRANS[1] & HREADY;
  assign accept    = ACTIVE_SUB & HREADY_SUB;

`ifdef BUSMATRIX_DMAC_SEQ2NONSEQ_EN
  // After re-arbitration the slave must see the burst restart.
  assign replay_trans = (hold_trans == 2'b11) ? 2'b10 : hold_trans;
`else
  assign replay_trans = hold_trans;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend       <= 1'b0;
      dphase     <= 1'b0;
      hold_addr  <= '0;
      hold_trans <= '0;
      hold_write <= 1'b0;
      hold_size  <= '0;
      hold_burst <= '0;
      hold_prot  <= '0;
    end else begin
      if (pend) begin
        if (accept) pend <= 1'b0;
      end else if (trans_req && !accept) begin
        pend       <= 1'b1;
        hold_addr  <= HADDR;
        hold_trans <= HTRANS;
        hold_write <= HWRITE;
        hold_size  <= HSIZE;
        hold_burst <= HBURST;
        hold_prot  <= HPROT;
      end
      if (HREADY_SUB) dphase <= accept & TRANS_HOLD_SUB & HTRANS_SUB[1];
    end
  end

  always_comb begin
    HSEL_SUB   = HSEL;
    HADDR_SUB  = HADDR;
    HTRANS_SUB = HTRANS;
    HWRITE_SUB = HWRITE;
    HSIZE_SUB  = HSIZE;
    HBURST_SUB = HBURST;
    HPROT_SUB  = HPROT;
    if (pend) begin
      HSEL_SUB   = 1'b1;
      HADDR_SUB  = hold_addr;
      HTRANS_SUB = replay_trans;
      HWRITE_SUB = hold_write;
      HSIZE_SUB  = hold_size;
      HBURST_SUB = hold_burst;
      HPROT_SUB  = hold_prot;
    end
  end

  assign TRANS_HOLD_SUB = pend | trans_req;
  assign HREADYOUT      = dphase ? HREADY_SUB : ~pend;
  assign HRESP          = 1'b0;
  assign HRDATA         = HRDATA_SUB;
  assign HWDATA_SUB     = HWDATA;

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage_dmac.sv
// Directed bench for the DMAC input stage: single-cycle vector table plus stall/reset sequences.
module tb_ahblite_busmatrix_inputstage_dmac;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        HSEL_SUB;
  logic [31:0] HADDR_SUB;
  logic [1:0]  HTRANS_SUB;
  logic        HWRITE_SUB;
  logic [2:0]  HSIZE_SUB;
  logic [2:0]  HBURST_SUB;
  logic [3:0]  HPROT_SUB;
  logic [31:0] HWDATA_SUB;
  logic        TRANS_HOLD_SUB;
  logic        ACTIVE_SUB;
  logic        HREADY_SUB;
  logic [31:0] HRDATA_SUB;

  int total = 0;
  int bad   = 0;

  ahblite_busmatrix_inputstage_dmac dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .HSEL_SUB(HSEL_SUB), .HADDR_SUB(HADDR_SUB), .HTRANS_SUB(HTRANS_SUB),
    .HWRITE_SUB(HWRITE_SUB), .HSIZE_SUB(HSIZE_SUB), .HBURST_SUB(HBURST_SUB),
    .HPROT_SUB(HPROT_SUB), .HWDATA_SUB(HWDATA_SUB), .TRANS_HOLD_SUB(TRANS_HOLD_SUB),
    .ACTIVE_SUB(ACTIVE_SUB), .HREADY_SUB(HREADY_SUB), .HRDATA_SUB(HRDATA_SUB)
  );

  always #5 HCLK = ~HCLK;

  // A new request while a transfer is held would be a master protocol error.
  always @(posedge HCLK) begin
    if (HRESETn && dut.pend && HSEL && HTRANS[1] && HREADY) begin
      $display("FAIL protocol: request while hold register valid");
      bad++;
    end
  end

  typedef struct {
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic        active;
    logic        exp_hsel_sub;
    logic [1:0]  exp_htrans_sub;
    logic        exp_hold;
    logic        exp_rdy;
    logic        exp_next_rdy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_master(input logic rdy);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = 32'h0;
    HREADY = rdy;
  endtask

  logic [1:0] exp_replay;

  initial begin
`ifdef BUSMATRIX_DMAC_SEQ2NONSEQ_EN
    exp_replay = 2'b10;
`else
    exp_replay = 2'b11;
`endif
    //            hsel addr          trans  hrdy act  hsel_s trans_s hold rdy next
    vecs[0] = '{1'b1, 32'h2000_0010, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h2000_0014, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 32'h2000_0018, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 32'h2000_001C, 2'b10, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'h2000_0020, 2'b10, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h2000_0024, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0};

    HRESETn = 1'b0;
    HWRITE = 1'b0; HSIZE = 3'b010; HBURST = 3'b000; HPROT = 4'h3;
    HWDATA = 32'h1234_5678; HRDATA_SUB = 32'h0BAD_F00D;
    ACTIVE_SUB = 1'b1; HREADY_SUB = 1'b1;
    idle_master(1'b1);
    HADDR = 32'h5555_AAAA;
    #2;
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'd0, HRESP}, 32'd0);
    chk("rst_hold", {31'd0, TRANS_HOLD_SUB}, 32'd0);
    chk("rst_haddr_pass", HADDR_SUB, 32'h5555_AAAA);
    chk("hwdata_pass", HWDATA_SUB, 32'h1234_5678);
    chk("hrdata_pass", HRDATA, 32'h0BAD_F00D);
    #10;
    HRESETn = 1'b1;
    cyc();

    // single-cycle vectors, each starting and ending with an idle port
    for (int i = 0; i < 6; i++) begin
      HSEL = vecs[i].hsel; HADDR = vecs[i].haddr; HTRANS = vecs[i].htrans;
      HREADY = vecs[i].hready; ACTIVE_SUB = vecs[i].active; HREADY_SUB = 1'b1;
      #2;
      chk($sformatf("v%0d_haddr_sub", i), HADDR_SUB, vecs[i].haddr);
      chk($sformatf("v%0d_hsel_sub", i), {31'd0, HSEL_SUB}, {31'd0, vecs[i].exp_hsel_sub});
      chk($sformatf("v%0d_htrans_sub", i), {30'd0, HTRANS_SUB}, {30'd0, vecs[i].exp_htrans_sub});
      chk($sformatf("v%0d_hold", i), {31'd0, TRANS_HOLD_SUB}, {31'd0, vecs[i].exp_hold});
      chk($sformatf("v%0d_hreadyout", i), {31'd0, HREADYOUT}, {31'd0, vecs[i].exp_rdy});
      cyc();
      idle_master(1'b0); HREADY_SUB = 1'b0;
      #2;
      chk($sformatf("v%0d_next_hreadyout", i), {31'd0, HREADYOUT}, {31'd0, vecs[i].exp_next_rdy});
      cyc();
      HREADY_SUB = 1'b1; HREADY = 1'b1;
      cyc();
    end

    // ungranted read: 3 cycles without grant, then grant
    HSEL = 1'b1; HADDR = 32'h4000_0100; HTRANS = 2'b10; HWRITE = 1'b0; HREADY = 1'b1;
    ACTIVE_SUB = 1'b0; HREADY_SUB = 1'b1;
    #2;
    chk("ug_c0_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("ug_c0_hold", {31'd0, TRANS_HOLD_SUB}, 32'd1);
    cyc();
    idle_master(1'b0); HADDR = 32'hDEAD_0000;
    for (int c = 1; c <= 3; c++) begin
      ACTIVE_SUB = (c == 3);
      #2;
      chk($sformatf("ug_c%0d_hreadyout", c), {31'd0, HREADYOUT}, 32'd0);
      chk($sformatf("ug_c%0d_haddr_sub", c), HADDR_SUB, 32'h4000_0100);
      chk($sformatf("ug_c%0d_hsel_sub", c), {31'd0, HSEL_SUB}, 32'd1);
      chk($sformatf("ug_c%0d_hold", c), {31'd0, TRANS_HOLD_SUB}, 32'd1);
      cyc();
    end
    HRDATA_SUB = 32'hCAFE_F00D;
    #2;
    chk("ug_data_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("ug_data_hrdata", HRDATA, 32'hCAFE_F00D);
    chk("ug_data_hold", {31'd0, TRANS_HOLD_SUB}, 32'd0);
    chk("ug_data_haddr_pass", HADDR_SUB, 32'hDEAD_0000);
    cyc();
    HREADY = 1'b1; HREADY_SUB = 1'b0;
    #2;
    chk("ug_after_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    HREADY_SUB = 1'b1;
    cyc();

    // granted write with two slave wait states
    HSEL = 1'b1; HADDR = 32'h2000_0020; HTRANS = 2'b10; HWRITE = 1'b1; HREADY = 1'b1;
    ACTIVE_SUB = 1'b1; HREADY_SUB = 1'b1;
    #2;
    chk("ws_addr_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    cyc();
    idle_master(1'b0); HREADY_SUB = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #2;
      chk($sformatf("ws_wait%0d_hreadyout", c), {31'd0, HREADYOUT}, 32'd0);
      cyc();
    end
    HREADY_SUB = 1'b1;
    #2;
    chk("ws_done_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    cyc();
    HREADY = 1'b1; HREADY_SUB = 1'b0;
    #2;
    chk("ws_cleared_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    HREADY_SUB = 1'b1;
    cyc();

    // SEQ captured without grant
    HSEL = 1'b1; HADDR = 32'h2000_0024; HTRANS = 2'b11; HWRITE = 1'b0; HREADY = 1'b1;
    ACTIVE_SUB = 1'b0;
    #2;
    chk("seq_pass_htrans", {30'd0, HTRANS_SUB}, 32'd3);
    cyc();
    idle_master(1'b0); ACTIVE_SUB = 1'b1;
    #2;
    chk("seq_replay_htrans", {30'd0, HTRANS_SUB}, {30'd0, exp_replay});
    chk("seq_replay_haddr", HADDR_SUB, 32'h2000_0024);
    chk("seq_replay_hreadyout", {31'd0, HREADYOUT}, 32'd0);
    cyc();
    #2;
    chk("seq_data_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    HREADY = 1'b1;
    cyc();

    // reset while a transfer is held
    HSEL = 1'b1; HADDR = 32'h3000_0000; HTRANS = 2'b10; HREADY = 1'b1; ACTIVE_SUB = 1'b0;
    cyc();
    idle_master(1'b0); HADDR = 32'h3000_00F0;
    #2;
    chk("rs_stall_hreadyout", {31'd0, HREADYOUT}, 32'd0);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("rs_async_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("rs_async_hold", {31'd0, TRANS_HOLD_SUB}, 32'd0);
    chk("rs_async_haddr", HADDR_SUB, 32'h3000_00F0);
    cyc();
    HRESETn = 1'b1;
    HSEL = 1'b1; HADDR = 32'h3000_0004; HTRANS = 2'b10; HREADY = 1'b1; ACTIVE_SUB = 1'b1;
    #2;
    chk("rs_next_haddr", HADDR_SUB, 32'h3000_0004);
    chk("rs_next_hold", {31'd0, TRANS_HOLD_SUB}, 32'd1);
    chk("rs_next_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    cyc();
    idle_master(1'b0); HREADY_SUB = 1'b0;
    #2;
    chk("rs_next_dphase", {31'd0, HREADYOUT}, 32'd0);
    HREADY_SUB = 1'b1;
    #2;
    chk("rs_next_done", {31'd0, HREADYOUT}, 32'd1);
    chk("hresp_okay", {31'd0, HRESP}, 32'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahblite_busmatrix_inputstage_dmac.md
# ahblite_busmatrix_inputstage_dmac

DMAC-side input stage of the AHB-Lite bus matrix. It sits between the DMA controller master port and the DMAC output stage. It accepts the master's address phase and forwards it combinationally when the output stage grants the port; otherwise it captures the phase in a one-deep hold register and replays it later. It also generates the master-side HREADYOUT/HRESP, stalling the master until the held transfer is accepted and its data phase completes downstream.

## Interface
- No parameters (32-bit address/data fixed).
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0]  in  -  master address phase
- HWDATA  in  32  master write data
- HREADY  in  1  master-side bus ready (address phase accepted when high)
- HREADYOUT  out  1  ready to master
- HRESP  out  1  response to master; constant 0 (OKAY)
- HRDATA  out  32  read data to master; equals HRDATA_SUB
- HSEL_SUB, HADDR_SUB[31:0], HTRANS_SUB[1:0], HWRITE_SUB, HSIZE_SUB[2:0], HBURST_SUB[2:0], HPROT_SUB[3:0]  out  -  address phase to output stage
- HWDATA_SUB  out  32  equals HWDATA
- TRANS_HOLD_SUB  out  1  transfer request to output stage
- ACTIVE_SUB  in  1  output stage has granted this port
- HREADY_SUB  in  1  HREADY driven by output stage toward slave
- HRDATA_SUB  in  32  read data from slave

## Operation
- trans_req = HSEL & HTRANS[1] & HREADY. IDLE/BUSY or HSEL=0 never raise a request.
- accept = ACTIVE_SUB & HREADY_SUB: the downstream address phase is taken this cycle.
- State bits:
  - pend: the hold register is valid.
  - dphase: this port owns a downstream data phase.
- Hold register: HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT.
  - Loads when trans_req & ~accept; pend<=1.
- pend clears when pend & accept; dphase<=1 on that edge.
- Address mux: pend=1 drives the *_SUB outputs from the hold register with HSEL_SUB=1. pend=0 passes the master signals through.
- TRANS_HOLD_SUB = pend | trans_req.
- dphase update on HREADY_SUB=1: dphase <= accept & TRANS_HOLD_SUB & HTRANS_SUB[1]. Holds while HREADY_SUB=0.
- HREADYOUT: dphase ? HREADY_SUB : (pend ? 0 : 1).
- trans_req while pend=1 is a protocol violation; the hold register is not overwritten (bench asserts).
- Write data is not buffered. The master keeps HWDATA stable while stalled.

## Timing
- Reset: pend=0, dphase=0, hold register 0.
  - HREADYOUT=1, HRESP=0, TRANS_HOLD_SUB=0.
  - *_SUB outputs follow master inputs.
- Granted, idle downstream: zero added latency. Address reaches the output stage in the same cycle.
- Ungranted: the master sees HREADYOUT=0 from the cycle after capture.
  - Stall lasts until the grant edge plus the slave data-phase length.
  - Minimum penalty: 1 cycle per cycle without grant.
- Simultaneous trans_req and accept with pend=0: pass-through, no capture.
- Back-to-back: the next master phase can be accepted in the same cycle dphase completes (HREADYOUT=1).
- Reset mid-stall: the held transfer is dropped and the master sees HREADYOUT=1.

## Configuration
- BUSMATRIX_DMAC_SEQ2NONSEQ_EN defined: a held transfer replayed with HTRANS=SEQ (2'b11) is presented as NONSEQ (2'b10). The downstream slave re-sees the burst start after re-arbitration.
- Undefined: the held HTRANS is replayed unchanged.
- Pass-through transfers are never modified.

## Test plan
- Granted write, ACTIVE_SUB=1, HREADY_SUB=1, HADDR=0x2000_0010 -> HADDR_SUB=0x2000_0010 the same cycle. HREADYOUT=1 throughout, pend never set.
- Ungranted read, ACTIVE_SUB=0 for 3 cycles, then 1 -> pend=1 and HREADYOUT=0 for 3 cycles. HADDR_SUB holds the captured address. Data returns one cycle after grant.
- Granted transfer with slave wait states, HREADY_SUB low for 2 cycles -> HREADYOUT mirrors HREADY_SUB (low 2 cycles); dphase clears after completion.
- SEQ captured while ungranted -> HTRANS_SUB=2'b10 with the macro defined, 2'b11 without.
- HRESETn pulsed low while pend=1 -> HREADYOUT=1, TRANS_HOLD_SUB=0 immediately (asynchronous); the next transfer proceeds normally.
- IDLE with HSEL=1 -> TRANS_HOLD_SUB=0, HREADYOUT=1, no state change.
